// File: rtl/video_timing_pkg.sv
// Shared types, default 640x480@60 timing constants and sizing helpers
// for the AXI4-Stream video timing engine.
package video_timing_pkg;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_e;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   function automatic int cnt_width(input int total);
      return (total <= 2) ? 1 : $clog2(total);
   endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Free-running h/v raster counters with a load port that jumps to the start
// of the vertical front porch, plus active-region and sync-window decode.
module video_timing_counter
   import video_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic active,
   output logic last_slot,
   output logic hs_win,
   output logic vs_win
);

   localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int HW      = cnt_width(H_TOTAL);
   localparam int VW      = cnt_width(V_TOTAL);

   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;

   // Load has priority so a lock lands on a known raster phase regardless of wrap.
   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (load) begin
         h_d = '0;
         v_d = VW'(V_ACTIVE);
      end else if (h_q == HW'(H_TOTAL - 1)) begin
         h_d = '0;
         v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
      end else begin
         h_d = h_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; the *_d values
   // above are computed with blocking assignments in always_comb, each given a
   // default first so no latch is inferred.
   always_ff @(posedge clk) begin
      if (rst) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   always_comb begin
      active    = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
      last_slot = (int'(h_q) == H_ACTIVE - 1) && (int'(v_q) == V_ACTIVE - 1);
      hs_win    = (int'(h_q) >= H_ACTIVE + H_FP) && (int'(h_q) < H_ACTIVE + H_FP + H_SYNC);
      vs_win    = (int'(v_q) >= V_ACTIVE + V_FP) && (int'(v_q) < V_ACTIVE + V_FP + V_SYNC);
   end

endmodule

// File: rtl/axis_video_timing.sv
// AXI4-Stream to video timing engine: lock FSM aligning stream tlast to the
// raster, one-pixel-per-active-slot handshake and registered video outputs.
module axis_video_timing
   import video_timing_pkg::*;
#(
   parameter int                H_ACTIVE = DEF_H_ACTIVE,
   parameter int                H_FP     = DEF_H_FP,
   parameter int                H_SYNC   = DEF_H_SYNC,
   parameter int                H_BP     = DEF_H_BP,
   parameter int                V_ACTIVE = DEF_V_ACTIVE,
   parameter int                V_FP     = DEF_V_FP,
   parameter int                V_SYNC   = DEF_V_SYNC,
   parameter int                V_BP     = DEF_V_BP,
   parameter bit                HS_POL   = 1'b0,
   parameter bit                VS_POL   = 1'b0,
   parameter int                DATA_W   = 24,
   parameter logic [DATA_W-1:0] FILL     = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              axis_tvalid,
   output logic              axis_tready,
   input  logic [DATA_W-1:0] axis_tdata,
   input  logic              axis_tlast,
   output logic [DATA_W-1:0] pix_data,
   output logic              de,
   output logic              hsync,
   output logic              vsync,
   output logic              locked,
   output logic              underflow,
   output logic              resync
);

   lock_state_e       state_q, state_d;
   logic              active, last_slot, hs_win, vs_win, load;
   logic [DATA_W-1:0] pix_data_q, pix_data_d;
   logic              de_q, hsync_q, vsync_q, underflow_q, underflow_d, resync_q, resync_d;

   video_timing_counter #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_counter (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .active    (active),
      .last_slot (last_slot),
      .hs_win    (hs_win),
      .vs_win    (vs_win)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= UNLOCKED;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         UNLOCKED: if (load)     state_d = LOCKED;
         LOCKED:   if (resync_d) state_d = UNLOCKED;
         default:                state_d = UNLOCKED;
      endcase
   end

   // While unlocked the source is drained every cycle until a tlast marks a frame edge.
   always_comb begin
      axis_tready = 1'b0;
      load        = 1'b0;
      pix_data_d  = FILL;
      underflow_d = 1'b0;
      resync_d    = 1'b0;
      if (!rst) begin
         case (state_q)
            UNLOCKED: begin
               axis_tready = 1'b1;
               load        = axis_tvalid && axis_tlast;
            end
            LOCKED: begin
               axis_tready = active;
               if (active && axis_tvalid) pix_data_d = axis_tdata;
               underflow_d = active && !axis_tvalid;
               resync_d    = active && axis_tvalid && (axis_tlast != last_slot);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pix_data_q  <= '0;
         de_q        <= 1'b0;
         hsync_q     <= !HS_POL;
         vsync_q     <= !VS_POL;
         underflow_q <= 1'b0;
         resync_q    <= 1'b0;
      end else begin
         pix_data_q  <= pix_data_d;
         de_q        <= active;
         hsync_q     <= hs_win ? HS_POL : !HS_POL;
         vsync_q     <= vs_win ? VS_POL : !VS_POL;
         underflow_q <= underflow_d;
         resync_q    <= resync_d;
      end
   end

   assign pix_data  = pix_data_q;
   assign de        = de_q;
   assign hsync     = hsync_q;
   assign vsync     = vsync_q;
   assign underflow = underflow_q;
   assign resync    = resync_q;
   assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_axis_video_timing.sv
// Bench for axis_video_timing on an 8x6 raster (4x3 active): directed stream
// scenarios plus a per-cycle comparison against a raster-position model.
module tb_axis_video_timing;

   localparam int HA = 4, HFP = 1, HSY = 2, HBP = 1;
   localparam int VA = 3, VFP = 1, VSY = 1, VBP = 1;
   localparam int HT = HA + HFP + HSY + HBP;
   localparam int VT = VA + VFP + VSY + VBP;
   localparam int TOT = HT * VT;

   logic        clk;
   logic        rst;
   logic        axis_tvalid, axis_tready, axis_tlast;
   logic [23:0] axis_tdata, pix_data;
   logic        de, hsync, vsync, locked, underflow, resync;

   int total = 0;
   int bad   = 0;

   axis_video_timing #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .HS_POL(1'b0), .VS_POL(1'b0), .DATA_W(24), .FILL(24'h0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .axis_tvalid (axis_tvalid),
      .axis_tready (axis_tready),
      .axis_tdata  (axis_tdata),
      .axis_tlast  (axis_tlast),
      .pix_data    (pix_data),
      .de          (de),
      .hsync       (hsync),
      .vsync       (vsync),
      .locked      (locked),
      .underflow   (underflow),
      .resync      (resync)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: raster tracked as a linear frame position p = v*HT + h.
   int          p = 0;
   bit          m_locked = 0, mvalid = 0;
   int          mh, mv;
   bit          m_act, m_acc, m_end, t_exp;
   logic        exp_de, exp_hs, exp_vs, exp_lk, exp_uf, exp_rs;
   logic [23:0] exp_pix;

   function automatic bit pos_active(input int pos);
      return ((pos % HT) < HA) && ((pos / HT) < VA);
   endfunction

   always @(negedge clk) begin
      t_exp = !rst && (!m_locked || pos_active(p));
      if (mvalid) begin
         check("tready",    axis_tready, t_exp);
         check("de",        de,        exp_de);
         check("hsync",     hsync,     exp_hs);
         check("vsync",     vsync,     exp_vs);
         check("pix_data",  pix_data,  exp_pix);
         check("locked",    locked,    exp_lk);
         check("underflow", underflow, exp_uf);
         check("resync",    resync,    exp_rs);
      end
      if (rst) begin
         p = 0; m_locked = 0; mvalid = 1;
         exp_de = 0; exp_hs = 1; exp_vs = 1; exp_pix = 24'h0;
         exp_lk = 0; exp_uf = 0; exp_rs = 0;
      end else if (mvalid) begin
         mh = p % HT;
         mv = p / HT;
         m_act = pos_active(p);
         m_acc = t_exp && axis_tvalid;
         m_end = (p == (VA - 1) * HT + HA - 1);
         exp_de  = m_act;
         exp_hs  = (mh >= HA + HFP && mh < HA + HFP + HSY) ? 1'b0 : 1'b1;
         exp_vs  = (mv >= VA + VFP && mv < VA + VFP + VSY) ? 1'b0 : 1'b1;
         exp_pix = (m_locked && m_acc) ? axis_tdata : 24'h0;
         exp_uf  = m_locked && m_act && !axis_tvalid;
         exp_rs  = m_locked && m_acc && (axis_tlast != m_end);
         if (!m_locked && m_acc && axis_tlast) begin
            m_locked = 1;
            p = VA * HT;
         end else begin
            if (exp_rs) m_locked = 0;
            p = (p + 1) % TOT;
         end
         exp_lk = m_locked;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one beat and hold it until the DUT accepts it; returns just after the accepting edge.
   task automatic beat(input logic [23:0] d, input logic l);
      int n = 0;
      axis_tvalid = 1'b1;
      axis_tdata  = d;
      axis_tlast  = l;
      while (!axis_tready && n < 200) begin
         step();
         n++;
      end
      if (n >= 200) begin
         total++;
         bad++;
         $display("FAIL beat_wait: no tready after %0d cycles", n);
      end
      step();
   endtask

   task automatic idle(input int n);
      axis_tvalid = 1'b0;
      axis_tlast  = 1'b0;
      repeat (n) step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not complete");
      $fatal(1, "timeout");
   end

   int de_cnt, hs_cnt, vs_cnt;

   initial begin
      rst = 1'b1; axis_tvalid = 1'b0; axis_tdata = '0; axis_tlast = 1'b0;

      // Reset held for three cycles.
      repeat (3) begin
         step();
         check("rst_hsync", hsync, 1'b1);
         check("rst_vsync", vsync, 1'b1);
         check("rst_de", de, 1'b0);
         check("rst_tready", axis_tready, 1'b0);
      end
      rst = 1'b0;
      step();
      check("unlocked_tready", axis_tready, 1'b1);
      check("unlocked_locked", locked, 1'b0);

      // Lock on the first tlast, then stream a full aligned frame.
      for (int i = 1; i <= 12; i++) beat(24'(i), i == 12);
      check("lock_after_tlast", locked, 1'b1);
      for (int i = 13; i <= 24; i++) begin
         beat(24'(i), i == 24);
         check("stream_pix", pix_data, 24'(i));
         check("stream_de", de, 1'b1);
      end
      check("still_locked", locked, 1'b1);

      // One full frame of raster with no data: 12 de, 2x6 hsync-low, one vsync-low line.
      axis_tvalid = 1'b0;
      de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
      for (int i = 0; i < TOT; i++) begin
         step();
         de_cnt += int'(de);
         hs_cnt += int'(!hsync);
         vs_cnt += int'(!vsync);
      end
      check("frame_de_count", de_cnt, 12);
      check("frame_hs_count", hs_cnt, 12);
      check("frame_vs_count", vs_cnt, 8);

      // Underflow at slot (h=2,v=1); the late stream then misses the last slot.
      for (int i = 0; i < 6; i++) beat(24'h100 + 24'(i), 1'b0);
      axis_tvalid = 1'b0;
      step();
      check("uf_pulse", underflow, 1'b1);
      check("uf_pix_fill", pix_data, 24'h0);
      check("uf_de", de, 1'b1);
      for (int i = 6; i < 11; i++) beat(24'h100 + 24'(i), 1'b0);
      check("uf_resync", resync, 1'b1);
      check("uf_unlocked", locked, 1'b0);
      beat(24'h10B, 1'b1);
      check("uf_relock", locked, 1'b1);

      // Early tlast on pixel 8.
      for (int i = 0; i < 8; i++) beat(24'h200 + 24'(i), i == 7);
      check("early_resync", resync, 1'b1);
      check("early_unlocked", locked, 1'b0);
      check("early_tready", axis_tready, 1'b1);
      axis_tvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("early_tready_cont", axis_tready, 1'b1);
      end
      beat(24'h2FF, 1'b1);
      check("early_relock", locked, 1'b1);

      // Twelfth pixel without tlast.
      for (int i = 0; i < 12; i++) beat(24'h300 + 24'(i), 1'b0);
      check("miss_resync", resync, 1'b1);
      check("miss_unlocked", locked, 1'b0);

      // Mid-frame reset at h=2, v=1.
      beat(24'h3FF, 1'b1);
      check("pre_rst_locked", locked, 1'b1);
      for (int i = 0; i < 6; i++) beat(24'h400 + 24'(i), 1'b0);
      rst = 1'b1;
      axis_tvalid = 1'b0;
      step();
      check("mid_rst_hsync", hsync, 1'b1);
      check("mid_rst_vsync", vsync, 1'b1);
      check("mid_rst_de", de, 1'b0);
      check("mid_rst_pix", pix_data, 24'h0);
      check("mid_rst_locked", locked, 1'b0);
      check("mid_rst_tready", axis_tready, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         beat(24'h500 + 24'(i), 1'b0);
         check("post_rst_unlocked", locked, 1'b0);
      end
      beat(24'h5FF, 1'b1);
      check("post_rst_relock", locked, 1'b1);

      idle(10);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
